// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: word width, opcodes, NOP encoding, loader state encoding.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        LD_LOAD = 2'd0,
        LD_RUN  = 2'd1,
        LD_ERR  = 2'd2
    } ld_state_e;
endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; lane counter wraps mod 4.
// Word strobe is combinational with the lane-3 byte; no backpressure of its own.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_dat_o
);
    logic [1:0]  lane_q, lane_d;
    logic [23:0] buf_q, buf_d;

    assign word_vld_o = byte_vld_i && (lane_q == 2'd3);
    assign word_dat_o = {byte_dat_i, buf_q};

    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        if (clr_i) begin
            lane_d = 2'd0;
        end else if (byte_vld_i) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    buf_d[7:0]   = byte_dat_i;
                2'd1:    buf_d[15:8]  = byte_dat_i;
                2'd2:    buf_d[23:16] = byte_dat_i;
                default: buf_d        = buf_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program byte stream into a word RAM, holds the core in reset until done,
// then answers instruction fetches one cycle after the request.
module instr_mem_loader
    import riscv_pkg::*;
#(
    parameter int               DEPTH  = 32,
    parameter int               ADDR_W = 5,
    parameter int               PC_W   = 8,
    parameter logic [XLEN-1:0]  NOP    = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    input  logic              reload,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_addr,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_instr,
    output logic              fetch_misalign,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);
    ld_state_e         state_q, state_d;
    logic              s_ready_q;
    logic              core_rst_q;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              fetch_valid_q, fetch_misalign_q, fetch_hit_q;
    logic [XLEN-1:0]   rd_dat_q;
    logic [XLEN-1:0]   mem [DEPTH];

    logic              byte_acc, mem_full, pk_byte_vld, pk_word_vld;
    logic [XLEN-1:0]   pk_word;
    logic              reload_take, fetch_take;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_aligned, fetch_in_range, fetch_hit;

    assign byte_acc    = s_valid && s_ready_q;
    assign mem_full    = (word_count_q == (ADDR_W+1)'(DEPTH));
    assign pk_byte_vld = byte_acc && !mem_full;
    assign reload_take = reload && (state_q != LD_LOAD);
    assign fetch_take  = fetch_req && (state_q == LD_RUN) && !reload;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (reload_take),
        .byte_vld_i (pk_byte_vld),
        .byte_dat_i (s_data),
        .word_vld_o (pk_word_vld),
        .word_dat_o (pk_word)
    );

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        case (state_q)
            LD_LOAD: begin
                if (byte_acc) begin
                    if (mem_full) begin
                        state_d = LD_ERR;
                    end else begin
                        if (pk_word_vld) word_count_d = word_count_q + 1'b1;
                        // s_last must land on lane 3, otherwise the partial word is an error
                        if (s_last) state_d = pk_word_vld ? LD_RUN : LD_ERR;
                    end
                end
            end
            LD_RUN, LD_ERR: begin
                if (reload) begin
                    state_d      = LD_LOAD;
                    word_count_d = '0;
                end
            end
            default: state_d = LD_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= LD_LOAD;
            s_ready_q        <= 1'b0;
            core_rst_q       <= 1'b1;
            word_count_q     <= '0;
            fetch_valid_q    <= 1'b0;
            fetch_misalign_q <= 1'b0;
            fetch_hit_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            s_ready_q        <= (state_d == LD_LOAD);
            core_rst_q       <= (state_q != LD_RUN) || reload_take;
            word_count_q     <= word_count_d;
            fetch_valid_q    <= fetch_take;
            fetch_misalign_q <= fetch_take && !fetch_aligned;
            fetch_hit_q      <= fetch_take && fetch_hit;
        end
    end

    assign fetch_idx      = fetch_addr[ADDR_W+1:2];
    assign fetch_aligned  = (fetch_addr[1:0] == 2'b00);
    assign fetch_in_range = (fetch_addr[PC_W-1:ADDR_W+2] == '0);
    // word_count gating hides stale RAM contents from earlier loads
    assign fetch_hit      = fetch_aligned && fetch_in_range && ({1'b0, fetch_idx} < word_count_q);

    always_ff @(posedge clk) begin
        if (pk_word_vld) mem[word_count_q[ADDR_W-1:0]] <= pk_word;
        rd_dat_q <= mem[fetch_idx];
    end

    assign s_ready        = s_ready_q;
    assign core_rst       = core_rst_q;
    assign load_done      = (state_q == LD_RUN);
    assign load_err       = (state_q == LD_ERR);
    assign word_count     = word_count_q;
    assign fetch_valid    = fetch_valid_q;
    assign fetch_misalign = fetch_misalign_q;
    assign fetch_instr    = !fetch_valid_q ? '0 : (fetch_hit_q ? rd_dat_q : NOP);
endmodule
